// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Boot-time loader sitting in front of the CPU's program RAM. A byte stream
// arrives over a valid/ready handshake in the form
//   count byte C (0 means 2^ADDR_W words), 2N data bytes high byte first,
//   XOR checksum of the data bytes.
// Each pair of data bytes is written as one word to consecutive RAM addresses
// starting at 0. The CPU core is held in reset until a load finishes with a
// matching checksum.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                one-cycle pulse; begins a load from IDLE/DONE/ERROR
//   in_valid, in_data    input byte stream
//   in_ready             loader accepts a byte this cycle
//   mem_we               one-cycle RAM write strobe per assembled word
//   mem_addr, mem_wdata  RAM write address / data (held between writes)
//   cpu_rst              CPU core reset, low only in DONE
//   done                 load complete with matching checksum
//   error                load failed
//   err_code             01 = checksum mismatch, 10 = timeout, 00 = none
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int              TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   TIMEOUT_V = TW'(TIMEOUT);
    localparam logic [ADDR_W:0] N_MAX     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_W     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [1:0]      ERR_NONE  = 2'b00;
    localparam logic [1:0]      ERR_CHK   = 2'b01;
    localparam logic [1:0]      ERR_TMO   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ADDR_W:0]   n_words;   // one bit wider so 2^ADDR_W fits
    logic [ADDR_W-1:0] index;
    logic [7:0]        chk;
    logic [7:0]        hi_byte;
    logic [TW-1:0]     timer;

    logic waiting;
    logic accept;
    logic timed_out;
    logic last_word;
    logic start_ok;

    // Idle-cycle counter step: stops at the limit so it cannot wrap while the
    // FSM is leaving for ERROR; never moves when the timeout is disabled.
    function automatic logic [TW-1:0] timer_step(input logic [TW-1:0] t);
        if (TIMEOUT == 0 || t == TIMEOUT_V)
            return t;
        return t + TW'(1);
    endfunction

    assign waiting   = (state == S_COUNT) || (state == S_HI) ||
                       (state == S_LO)    || (state == S_CHECK);
    assign accept    = in_valid && waiting;
    // A byte accepted on the limit cycle takes priority over the timeout.
    assign timed_out = (TIMEOUT != 0) && waiting && !accept && (timer == TIMEOUT_V);
    assign last_word = ({1'b0, index} == (n_words - ONE_W));
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) ||
                                 (state == S_ERROR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = waiting;
        mem_we   = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_COUNT;
            end
            S_COUNT: begin
                if (accept) state_nx = S_HI;
            end
            S_HI: begin
                if (accept) state_nx = S_LO;
            end
            S_LO: begin
                if (accept) state_nx = S_WRITE;
            end
            S_WRITE: begin
                mem_we   = 1'b1;
                state_nx = last_word ? S_CHECK : S_HI;
            end
            S_CHECK: begin
                if (accept) state_nx = (in_data == chk) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
                if (start) state_nx = S_COUNT;
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) state_nx = S_COUNT;
            end
            default: state_nx = S_IDLE;
        endcase
        if (timed_out) state_nx = S_ERROR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_words   <= '0;
            index     <= '0;
            chk       <= '0;
            hi_byte   <= '0;
            timer     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_code  <= ERR_NONE;
        end else begin
            if (start_ok) begin
                index    <= '0;
                chk      <= '0;
                timer    <= '0;
                err_code <= ERR_NONE;
            end

            if (waiting)
                timer <= accept ? '0 : timer_step(timer);

            if (timed_out)
                err_code <= ERR_TMO;

            case (state)
                S_COUNT: begin
                    if (accept)
                        n_words <= (in_data == 8'd0) ? N_MAX : (ADDR_W+1)'(in_data);
                end
                S_HI: begin
                    if (accept) begin
                        hi_byte <= in_data;
                        chk     <= chk ^ in_data;
                    end
                end
                S_LO: begin
                    // Address and data change together only when a word is
                    // complete, so they stay stable outside the write cycle.
                    if (accept) begin
                        mem_wdata <= DATA_W'({hi_byte, in_data});
                        mem_addr  <= index;
                        chk       <= chk ^ in_data;
                    end
                end
                S_WRITE: begin
                    index <= index + 1'b1;
                end
                S_CHECK: begin
                    if (accept && (in_data != chk))
                        err_code <= ERR_CHK;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Randomised and directed loads of program_loader. Each issued stream is
// turned by a reference model into the expected RAM writes and the expected
// final outcome; a monitor compares whatever the DUT presents against those
// queues.
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;
    logic [1:0]        err_code;

    program_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;
    typedef struct {
        bit         is_err;
        logic [1:0] code;
    } ev_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t wq[$];
    ev_t eq[$];
    bq_t q;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference model: what a stream must produce, derived from the format.
    task automatic expect_load(input bq_t bs);
        int         n;
        logic [7:0] x;
        n = (bs[0] == 8'd0) ? 256 : int'(bs[0]);
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
            wq.push_back('{addr: 8'(i), data: {bs[1 + 2*i], bs[2 + 2*i]}});
            x = x ^ bs[1 + 2*i] ^ bs[2 + 2*i];
        end
        if (bs[2*n + 1] == x)
            eq.push_back('{is_err: 1'b0, code: 2'b00});
        else
            eq.push_back('{is_err: 1'b1, code: 2'b01});
    endtask

    function automatic bq_t make_stream(input int n, input bit good, input bit fixed,
                                        input logic [7:0] fill);
        bq_t        s;
        logic [7:0] x;
        logic [7:0] b;
        x = 8'd0;
        s.push_back(8'(n));
        for (int i = 0; i < 2*n; i++) begin
            b = fixed ? fill : 8'($urandom);
            s.push_back(b);
            x = x ^ b;
        end
        s.push_back(good ? x : (x ^ 8'(1 + $urandom_range(254, 0))));
        return s;
    endfunction

    // Offers each byte until accepted; start is dropped after every edge so a
    // pulse set by the caller (or at byte start_at) lasts one cycle.
    task automatic send_bytes(input bq_t bs, input int gap_max, input int start_at);
        bit acc;
        int budget;
        for (int k = 0; k < bs.size(); k++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            in_valid = 1'b0;
            repeat (g) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = bs[k];
            if (k == start_at) start = 1'b1;
            acc    = 1'b0;
            budget = 0;
            while (!acc) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                budget++;
                if (!acc && budget > 50) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL byte_accept: byte %0d not accepted within %0d cycles", k, budget);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int c;
        c = 0;
        while (!(done || error) && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("load_end_seen", 32'(done || error), 32'd1);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic run_load(input bq_t bs, input int gap_max, input int start_at);
        expect_load(bs);
        start = 1'b1;
        send_bytes(bs, gap_max, start_at);
        wait_end();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_cpu_rst"},   32'(cpu_rst),   32'd1);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_error"},     32'(error),     32'd0);
        check({tag, "_err_code"},  32'(err_code),  32'd0);
    endtask

    // Monitor: every write strobe and every completion is matched against
    // the queues filled by the reference model.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (wq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                             mem_addr, mem_wdata);
                end else begin
                    check("write_addr", 32'(mem_addr),  32'(wq[0].addr));
                    check("write_data", 32'(mem_wdata), 32'(wq[0].data));
                    void'(wq.pop_front());
                end
            end
            if ((done && !prev_done) || (error && !prev_err)) begin
                if (eq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_end: got done %0d error %0d, required none",
                             done, error);
                end else begin
                    check("end_error",    32'(error),    32'(eq[0].is_err));
                    check("end_done",     32'(done),     32'(!eq[0].is_err));
                    check("end_err_code", 32'(err_code), 32'(eq[0].code));
                    check("end_cpu_rst",  32'(cpu_rst),  32'(eq[0].is_err));
                    void'(eq.pop_front());
                end
            end
        end
        prev_done <= done;
        prev_err  <= error;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-word load with in_valid held high: fixed completion latency.
        q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        expect_load(q);
        start = 1'b1;
        fork
            send_bytes(q, 0, -1);
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                check("done_latency_early", 32'(done), 32'd0);
                @(posedge clk);
                @(negedge clk);
                check("done_latency",    32'(done),    32'd1);
                check("cpu_rst_release", 32'(cpu_rst), 32'd0);
            end
        join
        wait_end();

        // Same stream, wrong checksum.
        q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        run_load(q, 0, -1);
        check("bad_chk_done",    32'(done),    32'd0);
        check("bad_chk_cpu_rst", 32'(cpu_rst), 32'd1);

        // Count byte 0: full 256-word load of A5A5, checksum 00.
        q = make_stream(256, 1'b1, 1'b1, 8'hA5);
        run_load(q, 0, -1);
        check("full_load_done", 32'(done), 32'd1);

        // Timeout: one data byte then silence.
        q = '{8'h01, 8'h5A};
        eq.push_back('{is_err: 1'b1, code: 2'b10});
        start = 1'b1;
        send_bytes(q, 0, -1);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("timeout_not_early", 32'(error), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (!error) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        check("timeout_error",    32'(error),    32'd1);
        check("timeout_err_code", 32'(err_code), 32'd2);
        check("timeout_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;

        // Reset while waiting for a low byte, then a clean reload.
        q = '{8'h03, 8'h77};
        start = 1'b1;
        send_bytes(q, 0, -1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        q = make_stream(4, 1'b1, 1'b0, 8'h00);
        run_load(q, 1, -1);

        // Start pulse in the middle of a load is ignored.
        q = make_stream(3, 1'b1, 1'b0, 8'h00);
        run_load(q, 1, 5);
        check("midload_start_done", 32'(done), 32'd1);

        // Start after DONE: CPU back in reset next cycle, count byte accepted.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("restart_cpu_rst",  32'(cpu_rst),  32'd1);
        check("restart_done",     32'(done),     32'd0);
        check("restart_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        q = make_stream(2, 1'b1, 1'b0, 8'h00);
        expect_load(q);
        send_bytes(q, 0, -1);
        wait_end();

        // Randomised loads with random gaps and random checksum corruption.
        for (int t = 0; t < 20; t++) begin
            int n;
            bit good;
            n    = int'($urandom_range(12, 1));
            good = ($urandom_range(3, 0) != 0);
            q    = make_stream(n, good, 1'b0, 8'h00);
            run_load(q, 3, -1);
        end

        repeat (3) @(negedge clk);
        check("writes_drained", 32'(wq.size()), 32'd0);
        check("events_drained", 32'(eq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
